// File: rtl/sram_bridge_pkg.sv
// rtl/sram_bridge_pkg.sv - shared types and constants for the Avalon-to-SRAM responder
package sram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  localparam int RD_WAIT_CYCLES_DEF  = 2;
  localparam int WR_PULSE_CYCLES_DEF = 1;
  localparam int CNT_W               = 4;

  // Strobe vector order is {ce_n, oe_n, we_n, ub_n, lb_n}
  localparam logic [4:0] STROBE_IDLE = 5'b11111;

endpackage

// File: rtl/sram_avalon_responder.sv
// rtl/sram_avalon_responder.sv - Avalon-MM slave driving an asynchronous 16-bit SRAM
module sram_avalon_responder
  import sram_bridge_pkg::*;
#(
  parameter int RD_WAIT_CYCLES  = RD_WAIT_CYCLES_DEF,
  parameter int WR_PULSE_CYCLES = WR_PULSE_CYCLES_DEF
) (
  input  logic        clk_0,
  input  logic        reset,
  input  logic [19:0] avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [15:0] avs_writedata,
  input  logic [1:0]  avs_byteenable,
  output logic [15:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       strobe, strobe_nxt;
  logic             dq_oe, dq_oe_nxt;
  logic [15:0]      wdata;
  logic [1:0]       be, be_nxt;

  assign avs_waitrequest = !(state == RD_DONE || state == WR_HOLD);
  assign {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N} = strobe;
  assign SRAM_DQ = dq_oe ? wdata : 16'hzzzz;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    be_nxt     = be;
    strobe_nxt = STROBE_IDLE;
    dq_oe_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (avs_write) begin
          state_nxt = WR_SETUP;
          be_nxt    = avs_byteenable;
        end else if (avs_read) begin
          state_nxt = RD_WAIT;
          cnt_nxt   = RD_LOAD;
        end
      end
      RD_WAIT: begin
        if (cnt == '0) state_nxt = RD_DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RD_DONE:  state_nxt = IDLE;
      WR_SETUP: begin
        state_nxt = WR_PULSE;
        cnt_nxt   = WR_LOAD;
      end
      WR_PULSE: begin
        if (cnt == '0) state_nxt = WR_HOLD;
        else           cnt_nxt   = cnt - 1'b1;
      end
      WR_HOLD:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    // Strobes are decoded from the next state so they leave the flops aligned with the state
    case (state_nxt)
      RD_WAIT, RD_DONE: strobe_nxt = 5'b00100;
      WR_SETUP, WR_HOLD: begin
        strobe_nxt = {3'b011, ~be_nxt};
        dq_oe_nxt  = 1'b1;
      end
      WR_PULSE: begin
        strobe_nxt = {2'b01, be_nxt == 2'b00, ~be_nxt};
        dq_oe_nxt  = 1'b1;
      end
      default: strobe_nxt = STROBE_IDLE;
    endcase
  end

  always_ff @(posedge clk_0 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      strobe       <= STROBE_IDLE;
      dq_oe        <= 1'b0;
      be           <= '0;
      wdata        <= '0;
      SRAM_ADDR    <= '0;
      avs_readdata <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      strobe <= strobe_nxt;
      dq_oe  <= dq_oe_nxt;
      be     <= be_nxt;
      if (state == IDLE && (avs_write || avs_read)) SRAM_ADDR <= avs_address;
      if (state == IDLE && avs_write) wdata <= avs_writedata;
      if (state == RD_WAIT && cnt == '0) avs_readdata <= SRAM_DQ;
    end
  end

endmodule

// File: tb/tb_sram_avalon_responder.sv
// tb/tb_sram_avalon_responder.sv - bench for sram_avalon_responder with SRAM model and cycle reference
module tb_sram_avalon_responder;

  localparam int RDN = 2;
  localparam int WRP = 1;

  logic        clk_0;
  logic        reset;
  logic [19:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [15:0] avs_writedata;
  logic [1:0]  avs_byteenable;
  logic [15:0] avs_readdata;
  logic        avs_waitrequest;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  sram_avalon_responder #(.RD_WAIT_CYCLES(RDN), .WR_PULSE_CYCLES(WRP)) dut (
    .clk_0(clk_0), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
  );

  initial clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  // External SRAM: 256 words, address aliased on the low 8 bits
  logic [15:0] sram_mem [0:255];
  logic [15:0] ref_mem  [0:255];

  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram_mem[SRAM_ADDR[7:0]] : 16'hzzzz;

  always @(posedge clk_0) begin
    if (!reset && !SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_UB_N) sram_mem[SRAM_ADDR[7:0]][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) sram_mem[SRAM_ADDR[7:0]][7:0]  <= SRAM_DQ[7:0];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One expected-output record per clock cycle of an access
  typedef struct packed {
    logic        wr;     // expected avs_waitrequest
    logic [4:0]  strb;   // {ce_n, oe_n, we_n, ub_n, lb_n}
    logic [1:0]  dqm;    // 0 released, 1 driven by DUT, 2 driven by SRAM
    logic [15:0] dqv;
    logic        na;     // SRAM_ADDR takes addr from this cycle on
    logic [19:0] addr;
    logic        nr;     // avs_readdata takes rdv from this cycle on
    logic [15:0] rdv;
  } exp_t;

  localparam exp_t IDLE_E = '{1'b1, 5'b11111, 2'd0, 16'h0, 1'b0, 20'h0, 1'b0, 16'h0};

  exp_t        q[$];
  logic        cmp_en     = 1'b0;
  logic [19:0] exp_addr   = '0;
  logic [15:0] exp_rdata  = '0;
  logic [15:0] last_wdata = 16'hA5C3;
  int          we_low     = 0;
  int          oe_low     = 0;

  always @(negedge clk_0) begin
    exp_t e;
    if (!reset) begin
      if (!SRAM_WE_N) we_low++;
      if (!SRAM_OE_N) oe_low++;
    end
    if (!reset && cmp_en) begin
      e = (q.size() != 0) ? q.pop_front() : IDLE_E;
      if (e.na) exp_addr = e.addr;
      if (e.nr) exp_rdata = e.rdv;
      chk("waitrequest", 32'(avs_waitrequest), 32'(e.wr));
      chk("strobes", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'(e.strb));
      chk("sram_addr", 32'(SRAM_ADDR), 32'(exp_addr));
      chk("readdata", 32'(avs_readdata), 32'(exp_rdata));
      if (e.dqm == 2'd0) begin
        n_chk++;
        if (SRAM_DQ === last_wdata) begin
          n_fail++;
          $display("FAIL dq_released: got %h, bus must not carry write data %h at %0t", SRAM_DQ, last_wdata, $time);
        end
      end else begin
        chk("dq_value", 32'(SRAM_DQ), 32'(e.dqv));
      end
    end
  end

  // Apply a request and append the cycles it must produce, starting with the sampling IDLE cycle
  task automatic push_model(input bit rd, input bit wr, input logic [19:0] a,
                            input logic [15:0] d, input logic [1:0] be);
    exp_t e;
    avs_address = a; avs_writedata = d; avs_byteenable = be;
    avs_read = rd; avs_write = wr;
    q.push_back(IDLE_E);
    if (wr) begin
      if (be[1]) ref_mem[a[7:0]][15:8] = d[15:8];
      if (be[0]) ref_mem[a[7:0]][7:0]  = d[7:0];
      last_wdata = d;
      e = '{1'b1, {3'b011, ~be}, 2'd1, d, 1'b1, a, 1'b0, 16'h0};
      q.push_back(e);
      e.na = 1'b0;
      e.strb = {2'b01, be == 2'b00, ~be};
      for (int i = 0; i < WRP; i++) q.push_back(e);
      e.strb = {3'b011, ~be};
      e.wr = 1'b0;
      q.push_back(e);
    end else if (rd) begin
      e = '{1'b1, 5'b00100, 2'd2, ref_mem[a[7:0]], 1'b1, a, 1'b0, 16'h0};
      for (int i = 0; i < RDN; i++) begin
        q.push_back(e);
        e.na = 1'b0;
      end
      e.wr = 1'b0; e.nr = 1'b1; e.rdv = ref_mem[a[7:0]];
      q.push_back(e);
    end
  endtask

  task automatic wait_done(output int lat);
    bit done = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_0);
      lat++;
      if (!avs_waitrequest) done = 1'b1;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL completion_timeout: got no completion, required one within 40 cycles");
    end
    @(posedge clk_0); #1;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    int lat, w0, o0, gap, kind;
    logic [19:0] a;
    logic [15:0] d;
    logic [1:0]  be;

    reset = 1'b1;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0;
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] <= 16'(i * 16'h0101) ^ 16'h3C3C;
      ref_mem[i]   = 16'(i * 16'h0101) ^ 16'h3C3C;
    end
    repeat (2) @(posedge clk_0);
    @(negedge clk_0);
    chk("rst_waitrequest", 32'(avs_waitrequest), 32'h1);
    chk("rst_readdata", 32'(avs_readdata), 32'h0);
    chk("rst_sram_addr", 32'(SRAM_ADDR), 32'h0);
    chk("rst_strobes", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'h1F);
    @(posedge clk_0); #1;
    reset = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk_0); #1;

    // Full-word write then back-to-back read of the same word
    w0 = we_low;
    push_model(1'b0, 1'b1, 20'h00012, 16'hBEEF, 2'b11);
    wait_done(lat);
    chk("wr_latency", 32'(lat), 32'd4);
    chk("wr_we_low_cycles", 32'(we_low - w0), 32'd1);
    chk("wr_sram_word", 32'(sram_mem[8'h12]), 32'hBEEF);
    push_model(1'b1, 1'b0, 20'h00012, 16'h0000, 2'b00);
    wait_done(lat);
    chk("rd_latency", 32'(lat), 32'd4);
    chk("rd_data", 32'(avs_readdata), 32'hBEEF);

    // Low-byte-only write into a word preset to all ones
    sram_mem[8'h34] <= 16'hFFFF;
    ref_mem[8'h34]   = 16'hFFFF;
    push_model(1'b0, 1'b1, 20'h00034, 16'h12AB, 2'b01);
    wait_done(lat);
    push_model(1'b1, 1'b0, 20'h00034, 16'h0000, 2'b11);
    wait_done(lat);
    chk("lane_rd_data", 32'(avs_readdata), 32'hFFAB);

    // Read and write together: the write wins and OE_N never falls
    o0 = oe_low;
    push_model(1'b1, 1'b1, 20'h00056, 16'h7E81, 2'b11);
    wait_done(lat);
    chk("both_latency", 32'(lat), 32'd4);
    chk("both_oe_low_cycles", 32'(oe_low - o0), 32'd0);
    chk("both_sram_word", 32'(sram_mem[8'h56]), 32'h7E81);

    // No byte lanes: WE_N stays high, access still completes
    w0 = we_low;
    push_model(1'b0, 1'b1, 20'h00078, 16'h3C5A, 2'b00);
    wait_done(lat);
    chk("nobe_latency", 32'(lat), 32'd4);
    chk("nobe_we_low_cycles", 32'(we_low - w0), 32'd0);

    // Reset in the middle of the write pulse, master keeps the request up
    push_model(1'b0, 1'b1, 20'h0009A, 16'hC3D2, 2'b10);
    repeat (3) @(negedge clk_0);
    #2 reset = 1'b1;
    #1;
    chk("abort_we_n", 32'(SRAM_WE_N), 32'h1);
    chk("abort_ce_n", 32'(SRAM_CE_N), 32'h1);
    chk("abort_waitrequest", 32'(avs_waitrequest), 32'h1);
    n_chk++;
    if (SRAM_DQ === 16'hC3D2) begin
      n_fail++;
      $display("FAIL abort_dq_released: got %h, bus must not carry write data", SRAM_DQ);
    end
    q.delete();
    exp_addr = '0;
    exp_rdata = '0;
    @(posedge clk_0); #1;
    chk("abort_hold_waitrequest", 32'(avs_waitrequest), 32'h1);
    @(posedge clk_0); #1;
    reset = 1'b0;
    push_model(1'b0, 1'b1, 20'h0009A, 16'hC3D2, 2'b10);
    wait_done(lat);
    chk("restart_latency", 32'(lat), 32'd4);
    chk("restart_sram_word", 32'(sram_mem[8'h9A]), 32'hC3A6);

    // Randomized accesses with random idle gaps
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 3);
      a  = {12'($urandom), 8'($urandom)};
      be = 2'($urandom);
      d  = 16'($urandom);
      while (d == 16'h0000 || d == 16'hFFFF) d = 16'($urandom);
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        repeat (gap) @(posedge clk_0);
        #1;
      end
      push_model(kind != 2, kind >= 2, a, d, be);
      wait_done(lat);
      chk("rand_latency", 32'(lat), (kind >= 2) ? 32'(WRP + 3) : 32'(RDN + 2));
    end

    repeat (3) @(posedge clk_0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_avalon_responder.md
SRAM_AVALON_RESPONDER -- requirements
Module: sram_avalon_responder

Interface
REQ-001 Parameter RD_WAIT_CYCLES, default 2, SRAM read access cycles (range 1..15).
REQ-002 Parameter WR_PULSE_CYCLES, default 1, width of the WE_N low pulse in cycles (range 1..15).
REQ-003 Clocking: one clock, clk_0; reset is asynchronous and active-high, named reset.
REQ-004 clk_0  in  1  50 MHz system clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 avs_address  in  20  SRAM word address.
REQ-007 avs_read  in  1  read request, held by the master until accepted.
REQ-008 avs_write  in  1  write request, held by the master until accepted.
REQ-009 avs_writedata  in  16  write data.
REQ-010 avs_byteenable  in  2  bit1 = upper byte, bit0 = lower byte.
REQ-011 avs_readdata  out  16  registered read data.
REQ-012 avs_waitrequest  out  1  low for exactly one cycle, the completion cycle.
REQ-013 SRAM_ADDR  out  20, SRAM_DQ  inout  16, SRAM_CE_N / SRAM_OE_N / SRAM_WE_N / SRAM_UB_N / SRAM_LB_N  out  1 each; all active-low strobes to the external SRAM.

Function
REQ-014 FSM states: IDLE, RD_WAIT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-015 avs_waitrequest is 0 only in RD_DONE and WR_HOLD and 1 in every other state, including IDLE; it is decoded from the registered state only, with no combinational path from avs_* inputs.
REQ-016 In IDLE with avs_write=1: latch address, data and byteenable, then go to WR_SETUP; avs_write has priority when avs_read and avs_write are both 1.
REQ-017 In IDLE with only avs_read=1: latch address, then go to RD_WAIT for RD_WAIT_CYCLES cycles, then to RD_DONE (1 cycle), then to IDLE.
REQ-018 Read strobes: CE_N=0, OE_N=0, UB_N=0, LB_N=0 during RD_WAIT and RD_DONE; byteenable is ignored for reads.
REQ-019 SRAM_DQ is sampled into avs_readdata on the final RD_WAIT edge; avs_readdata holds that value until the next read capture.
REQ-020 Read latency: 2+RD_WAIT_CYCLES cycles from the IDLE cycle that samples avs_read to the completion cycle inclusive (4 cycles at default).
REQ-021 Write sequence:
  - WR_SETUP (1 cycle): CE_N=0, WE_N=1, data driven.
  - WR_PULSE (WR_PULSE_CYCLES cycles): WE_N=0.
  - WR_HOLD (1 cycle): WE_N=1, data still driven, completion.
  - Then IDLE.
REQ-022 Write byte lanes: UB_N=~byteenable[1], LB_N=~byteenable[0]; with byteenable=2'b00, WE_N stays 1 throughout and the sequence still completes.
REQ-023 SRAM_DQ is driven only in WR_SETUP, WR_PULSE and WR_HOLD, and is high-Z in all other states.
REQ-024 Every access passes through at least one IDLE cycle; this is the bus-turnaround cycle between a write and a following read.
REQ-025 All SRAM_* outputs come from registers, so strobes are glitch-free.
REQ-026 Idle values: CE_N=OE_N=WE_N=UB_N=LB_N=1; SRAM_ADDR holds its last value.
REQ-027 The wait counter loads on state entry and counts down; it does not wrap.

Reset
REQ-028 While reset=1, the block is asynchronously forced to:
  - state IDLE; avs_waitrequest=1; avs_readdata=0; SRAM_ADDR=0;
  - all SRAM strobes=1; SRAM_DQ high-Z;
  - counter=0.
REQ-029 Reset asserted mid-access aborts the access immediately, releases DQ and leaves no completion pending; after reset deasserts, a request still held by the master is restarted from IDLE.

Structure
REQ-030 Package sram_bridge_pkg holds:
  - the state enum;
  - RD_WAIT_CYCLES and WR_PULSE_CYCLES defaults;
  - the counter width (4);
  - the idle strobe constant 5'b11111.
REQ-031 No sub-module: the FSM, counter and DQ tristate are in one module.

Verification
REQ-032 Write addr 0x00012, data 0xBEEF, byteenable 2'b11 -> WE_N low 1 cycle; DQ=0xBEEF through SETUP..HOLD; waitrequest low in the 4th cycle.
REQ-033 Read back addr 0x00012 with the SRAM model returning 0xBEEF -> OE_N low, avs_readdata=0xBEEF, waitrequest low in the 4th cycle; DQ not driven by the DUT.
REQ-034 Write 0x12AB with byteenable 2'b01 -> UB_N=1, LB_N=0; the model updates only the low byte; a read of a location preset to 0xFFFF returns 0xFFAB.
REQ-035 avs_read=avs_write=1 simultaneously -> the write is performed, a single completion occurs, OE_N stays 1.
REQ-036 Reset pulse during WR_PULSE -> WE_N=1 and DQ high-Z at once, waitrequest stays 1, and the restarted write completes after reset is released.
REQ-037 Back-to-back write then read -> at least one cycle with DQ high-Z and OE_N=1 between WR_HOLD and OE_N going low; no cycle has DQ driven while OE_N=0.
